// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with configurable width/depth, registered or
// first-word-fall-through read, fill-level trigger and sticky error flags.
module param_sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned FWFT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              push_in,
    input  logic              pop_in,
    input  logic              clr_err,
    input  logic [ADDR_W:0]   threshold,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              thre_trigger,
    output logic              overrun,
    output logic              underrun
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic              pop_acc_c;
    logic              push_acc_c;
    logic              ovr_set_c;
    logic              udr_set_c;
    logic [CNT_W-1:0]  count_nxt_c;

    // Handshake acceptance, error set conditions and next occupancy
    always_comb begin
        pop_acc_c   = en & pop_in & ~empty;
        push_acc_c  = en & push_in & (~full | pop_acc_c);
        ovr_set_c   = en & push_in & full & ~pop_acc_c;
        udr_set_c   = en & pop_in & empty;
        count_nxt_c = count;
        if (push_acc_c && !pop_acc_c) begin
            count_nxt_c = count + CNT_W'(1);
        end else if (pop_acc_c && !push_acc_c) begin
            count_nxt_c = count - CNT_W'(1);
        end
    end

    // Pointers, occupancy and flags; empty/full track the registered count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (push_acc_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_acc_c) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count    <= count_nxt_c;
            empty    <= (count_nxt_c == '0);
            full     <= (count_nxt_c == CNT_W'(DEPTH));
            // A set condition beats a simultaneous clear
            overrun  <= ovr_set_c | (overrun & ~clr_err);
            underrun <= udr_set_c | (underrun & ~clr_err);
        end
    end

    // Storage array; contents survive reset and are simply overwritten
    always_ff @(posedge clk) begin
        if (push_acc_c) begin
            mem[wr_ptr] <= din;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            // Registered read: head word captured on the popping edge
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout       <= '0;
                    dout_valid <= 1'b0;
                end else begin
                    dout_valid <= pop_acc_c;
                    if (pop_acc_c) begin
                        dout <= mem[rd_ptr];
                    end
                end
            end
        end else begin : g_fwft_read
            // Head word always visible; forced to zero while empty so reset shows 0
            assign dout       = empty ? '0 : mem[rd_ptr];
            assign dout_valid = ~empty;
        end
    endgenerate

    // Fill-level trigger on the registered occupancy
    assign thre_trigger = (count >= threshold);

endmodule
